alu_share_arb: RTL

Two-port arbiter and sequencer that shares the single 32-bit `alu` instance in the execute stage between two requesters: requester 0 is the pipeline EX stage and requester 1 is the auxiliary branch/address-compare unit. It accepts one operation at a time over a valid/ready handshake, chooses between requesters round-robin, and drives the ALU control and operands from registers. It captures `result` and `zero`, then returns them to the granted requester over a valid/ready response channel.

---
 rtl/alu_share_arb_if.sv | 76 +++++++
 rtl/alu_share_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb_if
// Description : Signal bundle between the two ALU requesters, the shared
//               ALU and the alu_share_arb sequencer.
//               req0/req1 : operation request channels (valid/ready)
//               rsp0/rsp1 : per-requester response channels (valid/ready)
//               alu_*     : registered ALU drive and ALU result/zero return
//               busy      : sequencer is not idle
//               slave modport is the arbiter's view; master is the
//               environment's view (requesters + ALU).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arb_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_ctl;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [4:0]        req0_shamt;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_ctl;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [4:0]        req1_shamt;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_zero;
  logic              rsp0_err;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_zero;
  logic              rsp1_err;

  logic [2:0]        alu_ctl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_shamt;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              busy;

  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b, req0_shamt,
    input  req1_valid, req1_ctl, req1_a, req1_b, req1_shamt,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output alu_ctl, alu_a, alu_b, alu_shamt,
    input  alu_result, alu_zero,
    output busy
  );

  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b, req0_shamt,
    output req1_valid, req1_ctl, req1_a, req1_b, req1_shamt,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  alu_ctl, alu_a, alu_b, alu_shamt,
    output alu_result, alu_zero,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin arbiter/sequencer sharing one 32-bit ALU between
//               the EX stage (requester 0) and the branch/address-compare
//               unit (requester 1). One operation in flight at a time:
//               accept -> EXEC (ALU evaluates) -> RESP (held until taken).
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - alu_share_arb_if.slave (request, response, ALU drive)
// Parameters  : DATA_W     - operand/result width (32 only)
//               START_PRIO - requester winning the first tie after reset
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
  parameter int DATA_W     = 32,
  parameter bit START_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_prio;       // requester that wins a tie
  logic              r_gnt;        // requester owning the in-flight op

  logic [2:0]        r_alu_ctl;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [4:0]        r_alu_shamt;

  logic              r_rsp0_valid;
  logic [DATA_W-1:0] r_rsp0_result;
  logic              r_rsp0_zero;
  logic              r_rsp0_err;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp1_result;
  logic              r_rsp1_zero;
  logic              r_rsp1_err;

  logic              w_any;
  logic              w_win;
  logic              w_hs;
  logic              w_accept;
  logic              w_supported;
  logic [2:0]        w_sel_ctl;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [4:0]        w_sel_shamt;

  // --------------------------------------------------------------------------
  // Arbitration and handshakes. Only request valids, response readys and
  // internal state feed the ready outputs; the ALU return never does.
  // --------------------------------------------------------------------------
  always_comb begin
    w_any    = bus.req0_valid | bus.req1_valid;
    // Single requester wins outright; a tie goes to the priority pointer.
    w_win    = (bus.req0_valid & bus.req1_valid) ? r_prio : bus.req1_valid;
    w_hs     = (r_state == S_RESP) & (r_gnt ? bus.rsp1_ready : bus.rsp0_ready);
    // rst_n gates acceptance so readys read 0 while reset is held.
    w_accept = rst_n & w_any & ((r_state == S_IDLE) | w_hs);
  end

  assign bus.req0_ready = w_accept & ~w_win;
  assign bus.req1_ready = w_accept &  w_win;

  assign w_sel_ctl   = w_win ? bus.req1_ctl   : bus.req0_ctl;
  assign w_sel_a     = w_win ? bus.req1_a     : bus.req0_a;
  assign w_sel_b     = w_win ? bus.req1_b     : bus.req0_b;
  assign w_sel_shamt = w_win ? bus.req1_shamt : bus.req0_shamt;

  // Op codes the ALU implements; 011 and 101 leave its output floating.
  always_comb begin
    w_supported = 1'b0;
    case (r_alu_ctl)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100: w_supported = 1'b1;
      default:                                        w_supported = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_hs) w_state_nxt = w_accept ? S_EXEC : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio        <= START_PRIO;
      r_gnt         <= 1'b0;
      r_alu_ctl     <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_shamt   <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_zero   <= 1'b0;
      r_rsp0_err    <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_zero   <= 1'b0;
      r_rsp1_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_ctl   <= w_sel_ctl;
        r_alu_a     <= w_sel_a;
        r_alu_b     <= w_sel_b;
        r_alu_shamt <= w_sel_shamt;
        r_gnt       <= w_win;
        r_prio      <= ~w_win;
      end

      // End of EXEC: capture into the owner's response registers only.
      if (r_state == S_EXEC) begin
        if (!r_gnt) begin
          r_rsp0_valid  <= 1'b1;
          r_rsp0_result <= w_supported ? bus.alu_result : '0;
          r_rsp0_zero   <= w_supported ? bus.alu_zero : 1'b1;
          r_rsp0_err    <= ~w_supported;
        end else begin
          r_rsp1_valid  <= 1'b1;
          r_rsp1_result <= w_supported ? bus.alu_result : '0;
          r_rsp1_zero   <= w_supported ? bus.alu_zero : 1'b1;
          r_rsp1_err    <= ~w_supported;
        end
      end

      // Response taken; r_gnt here is still the owner of the completed op.
      if (w_hs) begin
        if (!r_gnt) r_rsp0_valid <= 1'b0;
        else        r_rsp1_valid <= 1'b0;
      end
    end
  end

  assign bus.alu_ctl     = r_alu_ctl;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_shamt   = r_alu_shamt;

  assign bus.rsp0_valid  = r_rsp0_valid;
  assign bus.rsp0_result = r_rsp0_result;
  assign bus.rsp0_zero   = r_rsp0_zero;
  assign bus.rsp0_err    = r_rsp0_err;
  assign bus.rsp1_valid  = r_rsp1_valid;
  assign bus.rsp1_result = r_rsp1_result;
  assign bus.rsp1_zero   = r_rsp1_zero;
  assign bus.rsp1_err    = r_rsp1_err;

  assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
